// File: rtl/rv32i_cu_alu_dmem.sv
// RV32I decode/execute/memory slice: control decoder (ID),
// ALU (EX) and word-addressed data RAM (MEM) behind one wrapper.
module rv32i_cu_alu_dmem #(
  parameter int DMEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] cu_info,
  input  logic        cu_nop,
  output logic        we_reg,
  output logic        we_mem,
  output logic [2:0]  rf_sel,
  output logic [3:0]  alu_sel_o,
  output logic [1:0]  op2_sel,
  output logic        is_load,
  output logic        is_signed_o,
  output logic [1:0]  word_length,
  input  logic [31:0] alu_op1,
  input  logic [31:0] alu_op2,
  input  logic [3:0]  alu_sel,
  input  logic        alu_signed,
  output logic [31:0] alu_out,
  output logic        z,
  output logic        n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_AUI  = 7'b0010111;

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;
  localparam logic [3:0] A_AND = 4'b0010;
  localparam logic [3:0] A_OR  = 4'b0011;
  localparam logic [3:0] A_XOR = 4'b0100;
  localparam logic [3:0] A_SLL = 4'b0101;
  localparam logic [3:0] A_SRL = 4'b0110;
  localparam logic [3:0] A_SRA = 4'b0111;
  localparam logic [3:0] A_SLT = 4'b1000;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic [3:0] ar_op;
  logic       ar_sgn;

  assign opc = cu_info[6:0];
  assign f3  = cu_info[9:7];
  assign alt = cu_info[15];

  // funct3 mapping shared by OP and OP-IMM; SUB only exists for OP
  always_comb begin
    ar_op  = A_ADD;
    ar_sgn = 1'b0;
    case (f3)
      3'b000: ar_op = (opc == OPC_OP && alt) ? A_SUB : A_ADD;
      3'b001: ar_op = A_SLL;
      3'b010: begin
        ar_op  = A_SLT;
        ar_sgn = 1'b1;
      end
      3'b011: ar_op = A_SLT;
      3'b100: ar_op = A_XOR;
      3'b101: ar_op = alt ? A_SRA : A_SRL;
      3'b110: ar_op = A_OR;
      default: ar_op = A_AND;
    endcase
  end

  always_comb begin
    we_reg      = 1'b0;
    we_mem      = 1'b0;
    rf_sel      = 3'b000;
    alu_sel_o   = A_ADD;
    op2_sel     = 2'b00;
    is_load     = 1'b0;
    is_signed_o = 1'b0;
    word_length = 2'b00;
    if (!rst && !cu_nop) begin
      unique case (1'b1)
        opc == OPC_OP: begin
          op2_sel     = 2'b11;
          we_reg      = 1'b1;
          alu_sel_o   = ar_op;
          is_signed_o = ar_sgn;
        end
        opc == OPC_IMM: begin
          we_reg      = 1'b1;
          alu_sel_o   = ar_op;
          is_signed_o = ar_sgn;
        end
        opc == OPC_LD: begin
          we_reg      = 1'b1;
          rf_sel      = 3'b001;
          is_load     = 1'b1;
          word_length = f3[1:0];
          is_signed_o = ~f3[2];
        end
        opc == OPC_ST: begin
          op2_sel     = 2'b01;
          we_mem      = 1'b1;
          word_length = f3[1:0];
        end
        opc == OPC_BR: begin
          alu_sel_o   = A_SUB;
          op2_sel     = 2'b11;
          is_signed_o = ~f3[1];
        end
        opc == OPC_JAL: begin
          op2_sel = 2'b10;
          we_reg  = 1'b1;
          rf_sel  = 3'b011;
        end
        opc == OPC_JALR: begin
          we_reg = 1'b1;
          rf_sel = 3'b011;
        end
        opc == OPC_LUI: begin
          we_reg = 1'b1;
          rf_sel = 3'b010;
        end
        opc == OPC_AUI: begin
          we_reg = 1'b1;
          rf_sel = 3'b100;
        end
        default: ;
      endcase
    end
  end

  logic       lt;
  logic [4:0] sh;

  assign sh = alu_op2[4:0];
  assign lt = alu_signed ?
              ($signed(alu_op1) < $signed(alu_op2)) :
              (alu_op1 < alu_op2);

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      A_ADD: alu_out = alu_op1 + alu_op2;
      A_SUB: alu_out = alu_op1 - alu_op2;
      A_AND: alu_out = alu_op1 & alu_op2;
      A_OR:  alu_out = alu_op1 | alu_op2;
      A_XOR: alu_out = alu_op1 ^ alu_op2;
      A_SLL: alu_out = alu_op1 << sh;
      A_SRL: alu_out = alu_op1 >> sh;
      A_SRA: alu_out = $signed(alu_op1) >>> sh;
      A_SLT: alu_out = {31'b0, lt};
      default: alu_out = '0;
    endcase
  end

  assign z = (alu_out == '0);
  assign n = (alu_sel == A_SUB || alu_sel == A_SLT) ?
             lt : alu_out[31];

  logic [31:0]        mem [2**DMEM_AW];
  logic [DMEM_AW-1:0] idx;

  assign idx       = mem_addr[DMEM_AW+1:2];
  assign mem_rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[idx] <= mem_wdata;
  end

  logic unused;
  assign unused = ^{cu_info[16], cu_info[14:10],
                    mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

endmodule

// File: tb/tb_rv32i_cu_alu_dmem.sv
// Bench for rv32i_cu_alu_dmem: random stimulus checked every
// cycle against a behavioural model, plus literal spot checks.
module tb_rv32i_cu_alu_dmem;

  localparam int AW    = 10;
  localparam int DEPTH = 2**AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] cu_info;
  logic        cu_nop;
  logic        we_reg, we_mem, is_load, is_signed_o;
  logic [2:0]  rf_sel;
  logic [3:0]  alu_sel_o;
  logic [1:0]  op2_sel, word_length;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_signed, z, n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  rv32i_cu_alu_dmem #(.DMEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cu_info(cu_info), .cu_nop(cu_nop),
    .we_reg(we_reg), .we_mem(we_mem), .rf_sel(rf_sel),
    .alu_sel_o(alu_sel_o), .op2_sel(op2_sel),
    .is_load(is_load), .is_signed_o(is_signed_o),
    .word_length(word_length),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_signed(alu_signed), .alu_out(alu_out), .z(z), .n(n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mm [int];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // {we_reg, we_mem, rf_sel, alu, op2_sel, is_load, is_signed, wl}
  function automatic logic [14:0] cu_exp(logic [16:0] info,
                                          logic nop, logic r);
    int tab [8] = '{0, 5, 8, 8, 4, 6, 3, 2};
    int op = int'(info[6:0]);
    int f3 = int'(info[9:7]);
    bit alt = info[15];
    bit we = 0, wm = 0, ld = 0, sg = 0;
    int rf = 0, alu = 0, o2 = 0, wl = 0;
    if (r || nop) return '0;
    case (op)
      'h33, 'h13: begin
        we = 1;
        o2 = (op == 'h33) ? 3 : 0;
        alu = tab[f3];
        if (f3 == 0 && alt && op == 'h33) alu = 1;
        if (f3 == 5 && alt) alu = 7;
        sg = (f3 == 2);
      end
      'h03: begin
        we = 1; rf = 1; ld = 1;
        wl = f3 % 4; sg = (f3 < 4);
      end
      'h23: begin wm = 1; o2 = 1; wl = f3 % 4; end
      'h63: begin alu = 1; o2 = 3; sg = ((f3 & 2) == 0); end
      'h6f: begin we = 1; rf = 3; o2 = 2; end
      'h67: begin we = 1; rf = 3; end
      'h37: begin we = 1; rf = 2; end
      'h17: begin we = 1; rf = 4; end
      default: ;
    endcase
    return {we, wm, 3'(rf), 4'(alu), 2'(o2), ld, sg, 2'(wl)};
  endfunction

  // returns {n, z, out}
  function automatic logic [33:0] alu_exp(logic [31:0] a,
      logic [31:0] b, logic [3:0] s, logic sgn);
    longint sa = sgn ? longint'($signed(a)) : longint'(a);
    longint sb = sgn ? longint'($signed(b)) : longint'(b);
    bit lt = sa < sb;
    int k = int'(b % 32);
    logic [31:0] o;
    bit nf;
    case (s)
      0: o = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      1: o = 32'(longint'(a) + 64'h1_0000_0000 - longint'(b));
      2: o = a & b;
      3: o = a | b;
      4: o = a ^ b;
      5: o = 32'(longint'(a) * (longint'(1) << k));
      6: o = 32'(longint'(a) / (longint'(1) << k));
      7: o = 32'(longint'($signed(a)) >>> k);
      8: o = lt ? 32'd1 : 32'd0;
      default: o = 0;
    endcase
    nf = (s == 1 || s == 8) ? lt : o[31];
    return {nf, (o == 0), o};
  endfunction

  // every cycle: compare all outputs, then advance the memory model
  always @(negedge clk) begin
    automatic int key = int'((mem_addr >> 2) % DEPTH);
    chk("cu", 32'({we_reg, we_mem, rf_sel, alu_sel_o, op2_sel,
                   is_load, is_signed_o, word_length}),
        32'(cu_exp(cu_info, cu_nop, rst)));
    chk("alu", 32'({n, z}), 32'(alu_exp(alu_op1, alu_op2,
        alu_sel, alu_signed) >> 32));
    chk("alu_out", alu_out, alu_exp(alu_op1, alu_op2,
        alu_sel, alu_signed)[31:0]);
    if (mm.exists(key))
      chk("mem_rdata", mem_rdata, mm[key]);
    if (mem_we && !rst)
      mm[key] = mem_wdata;
  end

  task automatic drive_alu(logic [31:0] a, logic [31:0] b,
                           logic [3:0] s, logic sg);
    @(posedge clk); #1;
    alu_op1 = a; alu_op2 = b; alu_sel = s; alu_signed = sg;
    @(negedge clk); #1;
  endtask

  task automatic drive_mem(logic [31:0] a, logic [31:0] d,
                           logic we, logic r);
    @(posedge clk); #1;
    mem_addr = a; mem_wdata = d; mem_we = we; rst = r;
    @(negedge clk); #1;
  endtask

  logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};

  initial begin
    rst = 1; cu_nop = 0; cu_info = '0;
    alu_op1 = 0; alu_op2 = 0; alu_sel = 0; alu_signed = 0;
    mem_addr = 0; mem_wdata = 0; mem_we = 0;
    @(negedge clk); #1;
    chk("rst_cu", 32'({we_reg, rf_sel, is_load}), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    drive_alu(32'hFFFFFFFF, 1, 4'd0, 0);
    chk("add_out", alu_out, 0);
    chk("add_z", 32'(z), 1);
    drive_alu(32'hFFFFFFFF, 1, 4'd8, 1);
    chk("slt_s", {alu_out[30:0], n}, 32'h3);
    drive_alu(32'hFFFFFFFF, 1, 4'd8, 0);
    chk("slt_u", {alu_out[30:0], n}, 32'h0);
    drive_alu(32'h80000000, 1, 4'd1, 1);
    chk("sub_ovf", alu_out, 32'h7FFFFFFF);
    chk("sub_n", 32'(n), 1);
    drive_alu(32'h80000000, 4, 4'd7, 0);
    chk("sra", alu_out, 32'hF8000000);
    drive_alu(32'h80000000, 4, 4'd6, 0);
    chk("srl", alu_out, 32'h08000000);
    drive_alu(32'h12345678, 9, 4'd12, 0);
    chk("bad_sel", alu_out, 0);

    @(posedge clk); #1;
    cu_info = {7'b0100000, 3'b000, 7'b0110011};
    @(negedge clk); #1;
    chk("cu_sub", {alu_sel_o, op2_sel, we_reg}, 32'b0001_11_1);
    @(posedge clk); #1;
    cu_nop = 1;
    @(negedge clk); #1;
    chk("cu_nop", 32'({we_reg, we_mem, rf_sel, alu_sel_o,
        op2_sel, is_load, is_signed_o, word_length}), 0);
    @(posedge clk); #1;
    cu_nop = 0;
    cu_info = {7'b0, 3'b100, 7'b0000011};
    @(negedge clk); #1;
    chk("cu_lbu", {is_load, rf_sel, word_length, is_signed_o},
        32'b1_001_00_0);

    drive_mem(32'h10, 32'hDEADBEEF, 1, 0);
    drive_mem(32'h10, 32'h0, 0, 0);
    chk("mem_rd", mem_rdata, 32'hDEADBEEF);
    drive_mem(32'h13, 32'h0, 0, 0);
    chk("mem_off", mem_rdata, 32'hDEADBEEF);
    drive_mem(32'h10 + 4 * DEPTH, 32'h0, 0, 0);
    chk("mem_wrap", mem_rdata, 32'hDEADBEEF);
    drive_mem(32'h10, 32'h12345678, 1, 1);
    drive_mem(32'h10, 32'h0, 0, 0);
    chk("mem_rst", mem_rdata, 32'hDEADBEEF);
    drive_mem(32'h10, 32'hCAFEF00D, 1, 0);
    chk("mem_old", mem_rdata, 32'hDEADBEEF);
    drive_mem(32'h10, 32'h0, 0, 0);
    chk("mem_new", mem_rdata, 32'hCAFEF00D);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 15) == 0);
      cu_nop = ($urandom_range(0, 7) == 0);
      cu_info[6:0] = ($urandom_range(0, 4) == 0) ?
                     7'($urandom) : opcs[$urandom_range(0, 9)];
      cu_info[9:7] = 3'($urandom);
      case ($urandom_range(0, 2))
        0: cu_info[16:10] = 7'h00;
        1: cu_info[16:10] = 7'h20;
        default: cu_info[16:10] = 7'($urandom);
      endcase
      alu_op1 = ($urandom_range(0, 3) == 0) ?
                32'h80000000 : $urandom;
      alu_op2 = ($urandom_range(0, 3) == 0) ?
                32'($urandom_range(0, 40)) : $urandom;
      alu_sel = 4'($urandom_range(0, 10));
      alu_signed = 1'($urandom);
      mem_addr = {$urandom, 2'b00} & 32'hC000_0000;
      mem_addr = mem_addr | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3))
               | (32'($urandom_range(0, 1)) << (AW + 2));
      mem_wdata = $urandom;
      mem_we = 1'($urandom);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
